// File: rtl/crc_frame_seq.sv
// -----------------------------------------------------------------------------
// crc_frame_seq
// Sequencer for the 19-bit CRC generator in the DAQ readout path. It pops one
// event frame at a time from a first-word-fall-through FIFO. It then drives the
// generator so that the output stream is: header, CRC-covered data words,
// CRC low word, CRC high word, trailer.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   fifo_empty      FIFO empty flag (fifo_dout/fifo_eof valid when low)
//   fifo_dout       FIFO head word, bits [15:0] are CRC-covered payload
//   fifo_eof        head word is the last word of its frame
//   fifo_re         combinational pop, one word consumed per edge it is high
//   hold            downstream backpressure, forces a bubble this cycle
//   crc_d           registered generator data
//   crc_calc        registered generator opcode (0 init, 1 acc, 2 lo, 3 hi, 4 pass)
//   crc_dav         registered generator data-valid
//   busy            sequencer not idle
//   frame_done      one-cycle pulse registered with the trailer issue
//   err_len         sticky over-length flag, cleared on the next header
//   word_cnt        data words issued in the current frame
// -----------------------------------------------------------------------------
module crc_frame_seq #(
   parameter int unsigned MAX_WORDS    = 1024,
   parameter logic [18:0] TRAILER_WORD = 19'h0DE0F
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        fifo_empty,
   input  logic [18:0] fifo_dout,
   input  logic        fifo_eof,
   output logic        fifo_re,
   input  logic        hold,
   output logic [18:0] crc_d,
   output logic [2:0]  crc_calc,
   output logic        crc_dav,
   output logic        busy,
   output logic        frame_done,
   output logic        err_len,
   output logic [11:0] word_cnt
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_DATA   = 3'd1;
   localparam logic [2:0] S_CRC_LO = 3'd2;
   localparam logic [2:0] S_CRC_HI = 3'd3;
   localparam logic [2:0] S_TRAIL  = 3'd4;
   localparam logic [2:0] S_DRAIN  = 3'd5;

   localparam logic [2:0] CALC_INIT = 3'd0;
   localparam logic [2:0] CALC_ACC  = 3'd1;
   localparam logic [2:0] CALC_LO   = 3'd2;
   localparam logic [2:0] CALC_HI   = 3'd3;
   localparam logic [2:0] CALC_PASS = 3'd4;

   localparam logic [11:0] MAX_CNT = 12'(MAX_WORDS);

   logic [2:0]  state_q, state_d;
   logic [18:0] crc_d_q, crc_d_d;
   logic [2:0]  calc_q, calc_d;
   logic        dav_q, dav_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic [11:0] cnt_q, cnt_d;
   logic        pop_ok;

   assign pop_ok = !fifo_empty && !hold;

   always_comb begin
      // Default is a bubble: opcode 4 with dav=0 leaves the CRC register alone.
      state_d = state_q;
      crc_d_d = 19'd0;
      calc_d  = CALC_PASS;
      dav_d   = 1'b0;
      done_d  = 1'b0;
      err_d   = err_q;
      cnt_d   = cnt_q;
      fifo_re = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (pop_ok) begin
               fifo_re = 1'b1;
               crc_d_d = fifo_dout;
               calc_d  = CALC_INIT;
               dav_d   = 1'b1;
               cnt_d   = 12'd0;
               err_d   = 1'b0;
               state_d = fifo_eof ? S_CRC_LO : S_DATA;
            end
         end
         S_DATA: begin
            if (pop_ok) begin
               fifo_re = 1'b1;
               crc_d_d = fifo_dout;
               calc_d  = CALC_ACC;
               dav_d   = 1'b1;
               cnt_d   = cnt_q + 12'd1;
               if (fifo_eof) begin
                  state_d = S_CRC_LO;
               end else if (cnt_d == MAX_CNT) begin
                  err_d   = 1'b1;
                  state_d = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            // Discard the rest of an over-length frame; backpressure does not
            // matter here because nothing is issued.
            fifo_re = !fifo_empty;
            if (!fifo_empty && fifo_eof) begin
               state_d = S_CRC_LO;
            end
         end
         S_CRC_LO: begin
            if (!hold) begin
               calc_d  = CALC_LO;
               dav_d   = 1'b1;
               state_d = S_CRC_HI;
            end
         end
         S_CRC_HI: begin
            if (!hold) begin
               calc_d  = CALC_HI;
               dav_d   = 1'b1;
               state_d = S_TRAIL;
            end
         end
         S_TRAIL: begin
            if (!hold) begin
               crc_d_d = TRAILER_WORD;
               calc_d  = CALC_PASS;
               dav_d   = 1'b1;
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // No word may be consumed while the sequencer is being reset.
      if (rst) begin
         fifo_re = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         crc_d_q <= 19'd0;
         calc_q  <= CALC_PASS;
         dav_q   <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= 12'd0;
      end else begin
         state_q <= state_d;
         crc_d_q <= crc_d_d;
         calc_q  <= calc_d;
         dav_q   <= dav_d;
         done_q  <= done_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign crc_d      = crc_d_q;
   assign crc_calc   = calc_q;
   assign crc_dav    = dav_q;
   assign frame_done = done_q;
   assign err_len    = err_q;
   assign word_cnt   = cnt_q;
   assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_crc_frame_seq.sv
module tb_crc_frame_seq;

   localparam logic [18:0] TRAILER = 19'h0DE0F;

   logic        clk;
   logic        rst;
   logic        fifo_empty;
   logic [18:0] fifo_dout;
   logic        fifo_eof;
   logic        fifo_re;
   logic        hold;
   logic [18:0] crc_d;
   logic [2:0]  crc_calc;
   logic        crc_dav;
   logic        busy;
   logic        frame_done;
   logic        err_len;
   logic [11:0] word_cnt;

   crc_frame_seq #(
      .MAX_WORDS    (8),
      .TRAILER_WORD (TRAILER)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .fifo_empty (fifo_empty),
      .fifo_dout  (fifo_dout),
      .fifo_eof   (fifo_eof),
      .fifo_re    (fifo_re),
      .hold       (hold),
      .crc_d      (crc_d),
      .crc_calc   (crc_calc),
      .crc_dav    (crc_dav),
      .busy       (busy),
      .frame_done (frame_done),
      .err_len    (err_len),
      .word_cnt   (word_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // FIFO model entries are {eof, word}; scoreboard entries are {frame_done, calc, d}.
   logic [19:0] fifo_q[$];
   logic [22:0] exp_q[$];
   bit          force_empty;
   int          checks;
   int          errors;
   int          bubbles;
   int          frames;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic apply_fifo();
      logic [19:0] head;
      if (fifo_q.size() == 0 || force_empty) begin
         fifo_empty = 1'b1;
         fifo_dout  = 19'd0;
         fifo_eof   = 1'b0;
      end else begin
         head       = fifo_q[0];
         fifo_empty = 1'b0;
         fifo_dout  = head[18:0];
         fifo_eof   = head[19];
      end
   endtask

   // One clock: present the FIFO head, pop on the edge if the DUT asked to,
   // then score whatever was issued.
   task automatic cycle();
      logic        re_s;
      logic [19:0] popped;
      logic [22:0] e;
      apply_fifo();
      #2;
      if (rst) check("re_in_reset", 32'(fifo_re), 32'd0);
      else     check("re_when_empty", 32'(fifo_re & fifo_empty), 32'd0);
      re_s = fifo_re;
      @(posedge clk);
      if (re_s) popped = fifo_q.pop_front();
      #1;
      if (rst) begin
         check("reset_outputs",
               32'({crc_d, crc_calc, crc_dav, busy, frame_done, err_len, word_cnt}),
               32'({19'd0, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0}));
      end else if (crc_dav) begin
         if (frame_done) frames++;
         checks++;
         assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_issue: observed calc=%0d d=%h expected no issue", crc_calc, crc_d);
         end
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            $display("issue calc=%0d d=%05h done=%0d", crc_calc, crc_d, frame_done);
            check("issue", 32'({frame_done, crc_calc, crc_d}), 32'(e));
         end
      end else begin
         bubbles++;
         check("bubble", 32'({frame_done, crc_calc, crc_d}), 32'({1'b0, 3'd4, 19'd0}));
      end
   endtask

   task automatic run_until_done(input int budget);
      int n;
      n = 0;
      while (exp_q.size() > 0 && n < budget) begin
         cycle();
         n++;
      end
      checks++;
      assert (exp_q.size() == 0) else begin
         errors++;
         $error("FAIL timeout: observed %0d issues outstanding expected 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   // Header, then n data words base+1..base+n; eof on the last word.
   task automatic push_frame(input logic [18:0] hdr, input int n, input int base);
      fifo_q.push_back({(n == 0), hdr});
      for (int i = 1; i <= n; i++) begin
         fifo_q.push_back({(i == n), 19'(base + i)});
      end
   endtask

   // Expected issue stream: header, n_acc accumulates, CRC lo/hi, trailer.
   task automatic expect_frame(input logic [18:0] hdr, input int n_acc, input int base);
      exp_q.push_back({1'b0, 3'd0, hdr});
      for (int i = 1; i <= n_acc; i++) begin
         exp_q.push_back({1'b0, 3'd1, 19'(base + i)});
      end
      exp_q.push_back({1'b0, 3'd2, 19'd0});
      exp_q.push_back({1'b0, 3'd3, 19'd0});
      exp_q.push_back({1'b1, 3'd4, TRAILER});
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      bubbles     = 0;
      frames      = 0;
      force_empty = 1'b0;
      hold        = 1'b0;
      rst         = 1'b1;
      for (int i = 0; i < 3; i++) cycle();
      rst = 1'b0;
      cycle();

      // Header-only frame
      push_frame(19'h1ABCD, 0, 0);
      expect_frame(19'h1ABCD, 0, 0);
      bubbles = 0;
      run_until_done(20);
      check("hdr_only_bubbles", 32'(bubbles), 32'd0);
      check("hdr_only_word_cnt", 32'(word_cnt), 32'd0);
      check("hdr_only_busy", 32'(busy), 32'd0);

      // 4-word frame
      push_frame(19'h10002, 4, 0);
      expect_frame(19'h10002, 4, 0);
      bubbles = 0;
      run_until_done(20);
      check("f4_bubbles", 32'(bubbles), 32'd0);
      check("f4_word_cnt", 32'(word_cnt), 32'd4);
      check("f4_err_len", 32'(err_len), 32'd0);

      // Same frame with a 3-cycle empty gap and hold during CRC_LO
      push_frame(19'h10002, 4, 0);
      expect_frame(19'h10002, 4, 0);
      bubbles = 0;
      for (int i = 0; i < 3; i++) cycle();
      check("gap_busy", 32'(busy), 32'd1);
      check("gap_word_cnt", 32'(word_cnt), 32'd2);
      force_empty = 1'b1;
      for (int i = 0; i < 3; i++) cycle();
      force_empty = 1'b0;
      for (int i = 0; i < 2; i++) cycle();
      hold = 1'b1;
      cycle();
      hold = 1'b0;
      run_until_done(20);
      check("gap_bubbles", 32'(bubbles), 32'd4);
      check("gap_word_cnt_end", 32'(word_cnt), 32'd4);

      // Exactly MAX_WORDS data words with eof on the last: no length error
      push_frame(19'h10008, 8, 16'h100);
      expect_frame(19'h10008, 8, 16'h100);
      bubbles = 0;
      run_until_done(30);
      check("max_err_len", 32'(err_len), 32'd0);
      check("max_word_cnt", 32'(word_cnt), 32'd8);
      check("max_bubbles", 32'(bubbles), 32'd0);

      // Over-length frame: 12 words, only 8 accumulated, 4 drained under hold
      push_frame(19'h1000C, 12, 16'h200);
      expect_frame(19'h1000C, 8, 16'h200);
      bubbles = 0;
      for (int i = 0; i < 9; i++) cycle();
      check("ovl_err_len", 32'(err_len), 32'd1);
      check("ovl_word_cnt", 32'(word_cnt), 32'd8);
      hold = 1'b1;
      for (int i = 0; i < 4; i++) cycle();
      hold = 1'b0;
      check("ovl_drained", 32'(fifo_q.size()), 32'd0);
      run_until_done(20);
      check("ovl_bubbles", 32'(bubbles), 32'd4);
      check("ovl_err_sticky", 32'(err_len), 32'd1);
      check("ovl_word_cnt_end", 32'(word_cnt), 32'd8);
      push_frame(19'h1F00F, 0, 0);
      expect_frame(19'h1F00F, 0, 0);
      cycle();
      check("err_clear_on_hdr", 32'(err_len), 32'd0);
      run_until_done(20);

      // Reset in the middle of DATA, then a fresh frame
      push_frame(19'h10006, 6, 16'h300);
      expect_frame(19'h10006, 6, 16'h300);
      for (int i = 0; i < 3; i++) cycle();
      check("rst_pre_word_cnt", 32'(word_cnt), 32'd2);
      rst = 1'b1;
      cycle();
      cycle();
      check("rst_fifo_untouched", 32'(fifo_q.size()), 32'd4);
      exp_q.delete();
      fifo_q.delete();
      rst = 1'b0;
      push_frame(19'h10002, 4, 0);
      expect_frame(19'h10002, 4, 0);
      bubbles = 0;
      run_until_done(20);
      check("post_rst_bubbles", 32'(bubbles), 32'd0);
      check("post_rst_word_cnt", 32'(word_cnt), 32'd4);

      // Two frames back to back: no bubble between trailer and next header
      push_frame(19'h10AAA, 2, 16'h400);
      push_frame(19'h10BBB, 1, 16'h500);
      expect_frame(19'h10AAA, 2, 16'h400);
      expect_frame(19'h10BBB, 1, 16'h500);
      bubbles = 0;
      frames  = 0;
      run_until_done(30);
      check("b2b_bubbles", 32'(bubbles), 32'd0);
      check("b2b_frames", 32'(frames), 32'd2);
      check("b2b_fifo_empty", 32'(fifo_q.size()), 32'd0);
      cycle();
      check("idle_busy", 32'(busy), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
